alu_exec_ctrl: RTL and testbench

Execute-stage initiator for the ALU's `opsel`/`ready` interface. Accepts one decoded operation from decode through a valid/ready handshake and drives the ALU operand and opcode inputs until the ALU raises `ready`. It then captures the result, extra result and next flags, owns the architectural flag register (which feeds `Cflag`/`Oflag` back to the ALU), and performs one or two register-file writebacks. It sits between decode and the register-file write port.

---
 rtl/alu_exec_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
// Execute-stage initiator for the ALU opsel/ready interface. It takes one
// decoded operation over a valid/ready handshake and holds the ALU operands
// and opcode stable until the ALU answers with ready. It then writes the
// result (and optionally the extra result) to the register file, and it owns
// the architectural flag register.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   dec_*               decoded operation and its handshake (dec_ready out)
//   alu_srcA/B/extra_X  operands to the ALU; alu_opsel is the opcode
//   alu_Cflag/Oflag     carry/overflow from the flag register, fed to the ALU
//   alu_res/extra_res   results from the ALU; alu_flag_next, alu_ready
//   rf_we/waddr/wdata   register-file write port (addr/data are 0 when idle)
//   flags               {ZF,NF,CF,OF}
//   done                one-cycle pulse on the last writeback of an op
//   err / err_clr       sticky timeout indication and its clear
module alu_exec_ctrl #(
    parameter int REG_AW   = 4,
    parameter int MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [15:0]       dec_srcA,
    input  logic [15:0]       dec_srcB,
    input  logic [15:0]       dec_extra_X,
    input  logic [4:0]        dec_opsel,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic [REG_AW-1:0] dec_rd_hi,
    input  logic              dec_wr_extra,
    input  logic              dec_wr_flags,
    output logic [15:0]       alu_srcA,
    output logic [15:0]       alu_srcB,
    output logic [15:0]       alu_extra_X,
    output logic [4:0]        alu_opsel,
    output logic              alu_Cflag,
    output logic              alu_Oflag,
    input  logic [15:0]       alu_res,
    input  logic [15:0]       alu_extra_res,
    input  logic [3:0]        alu_flag_next,
    input  logic              alu_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [15:0]       rf_wdata,
    output logic [3:0]        flags,
    output logic              done,
    output logic              err,
    input  logic              err_clr
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WB_LO = 2'd2,
        S_WB_HI = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_alu_done;
    logic              w_timeout;
    logic              w_wb_hi;

    logic [CW-1:0]     r_wait_cnt;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rd_hi;
    logic              r_wr_extra;
    logic              r_wr_flags;
    logic [15:0]       r_extra_res;
    logic [15:0]       r_alu_srcA;
    logic [15:0]       r_alu_srcB;
    logic [15:0]       r_alu_extra_X;
    logic [4:0]        r_alu_opsel;
    logic [3:0]        r_flags;
    logic              r_err;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [15:0]       r_rf_wdata;
    logic              r_done;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and the per-cycle events that steer the datapath
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_alu_done   = 1'b0;
        w_timeout    = 1'b0;
        w_wb_hi      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dec_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EXEC;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                if (alu_ready) begin
                    w_alu_done   = 1'b1;
                    w_next_state = S_WB_LO;
                end else if (r_wait_cnt == LAST_WAIT) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_WB_LO: begin
                if (r_wr_extra) begin
                    w_wb_hi      = 1'b1;
                    w_next_state = S_WB_HI;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WB_HI: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operation latches, wait counter and captured extra result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt    <= {CW{1'b0}};
            r_rd          <= {REG_AW{1'b0}};
            r_rd_hi       <= {REG_AW{1'b0}};
            r_wr_extra    <= 1'b0;
            r_wr_flags    <= 1'b0;
            r_extra_res   <= 16'h0000;
            r_alu_srcA    <= 16'h0000;
            r_alu_srcB    <= 16'h0000;
            r_alu_extra_X <= 16'h0000;
            r_alu_opsel   <= 5'd0;
        end else begin
            if (w_accept) begin
                r_wait_cnt    <= {CW{1'b0}};
                r_rd          <= dec_rd;
                r_rd_hi       <= dec_rd_hi;
                r_wr_extra    <= dec_wr_extra;
                r_wr_flags    <= dec_wr_flags;
                r_alu_srcA    <= dec_srcA;
                r_alu_srcB    <= dec_srcB;
                r_alu_extra_X <= dec_extra_X;
                r_alu_opsel   <= dec_opsel;
            end else if ((r_state == S_EXEC) && !alu_ready && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
            if (w_alu_done) begin
                r_extra_res <= alu_extra_res;
            end
        end
    end

    // Architectural flags and the sticky timeout error (a timeout beats err_clr)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            if (w_alu_done && r_wr_flags) begin
                r_flags <= alu_flag_next;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Registered write port: loaded on the edge that enters WB_LO / WB_HI
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= {REG_AW{1'b0}};
            r_rf_wdata <= 16'h0000;
            r_done     <= 1'b0;
        end else if (w_alu_done) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= r_rd;
            r_rf_wdata <= alu_res;
            r_done     <= !r_wr_extra;
        end else if (w_wb_hi) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= r_rd_hi;
            r_rf_wdata <= r_extra_res;
            r_done     <= 1'b1;
        end else begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= {REG_AW{1'b0}};
            r_rf_wdata <= 16'h0000;
            r_done     <= 1'b0;
        end
    end

    assign dec_ready   = (r_state == S_IDLE);
    assign alu_srcA    = r_alu_srcA;
    assign alu_srcB    = r_alu_srcB;
    assign alu_extra_X = r_alu_extra_X;
    assign alu_opsel   = r_alu_opsel;
    assign alu_Cflag   = r_flags[1];
    assign alu_Oflag   = r_flags[0];
    assign flags       = r_flags;
    assign err         = r_err;
    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign done        = r_done;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl. The expected behaviour is a per-cycle timeline:
// each issued op writes into it, from the op's own delay/timeout choice,
// when the block is busy, when and what it writes, and from when the flags,
// err and held ALU operands change. One process compares every cycle.
module tb_alu_exec_ctrl;

    localparam int MW   = 8;
    localparam int MAXC = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [15:0] dec_srcA = 16'h0, dec_srcB = 16'h0, dec_extra_X = 16'h0;
    logic [4:0]  dec_opsel = 5'd0;
    logic [3:0]  dec_rd = 4'd0, dec_rd_hi = 4'd0;
    logic        dec_wr_extra = 1'b0, dec_wr_flags = 1'b0;
    logic [15:0] alu_srcA, alu_srcB, alu_extra_X;
    logic [4:0]  alu_opsel;
    logic        alu_Cflag, alu_Oflag;
    logic [15:0] alu_res = 16'h0, alu_extra_res = 16'h0;
    logic [3:0]  alu_flag_next = 4'd0;
    logic        alu_ready = 1'b0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [3:0]  flags;
    logic        done, err;
    logic        err_clr = 1'b0;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    logic        e_dr    [MAXC];
    logic        e_we    [MAXC];
    logic [3:0]  e_addr  [MAXC];
    logic [15:0] e_data  [MAXC];
    logic        e_done  [MAXC];
    logic [3:0]  e_flags [MAXC];
    logic        e_err   [MAXC];
    logic [15:0] e_a     [MAXC];
    logic [15:0] e_b     [MAXC];
    logic [15:0] e_x     [MAXC];
    logic [4:0]  e_op    [MAXC];

    alu_exec_ctrl #(.REG_AW(4), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_srcA(dec_srcA), .dec_srcB(dec_srcB), .dec_extra_X(dec_extra_X),
        .dec_opsel(dec_opsel), .dec_rd(dec_rd), .dec_rd_hi(dec_rd_hi),
        .dec_wr_extra(dec_wr_extra), .dec_wr_flags(dec_wr_flags),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_extra_X(alu_extra_X),
        .alu_opsel(alu_opsel), .alu_Cflag(alu_Cflag), .alu_Oflag(alu_Oflag),
        .alu_res(alu_res), .alu_extra_res(alu_extra_res),
        .alu_flag_next(alu_flag_next), .alu_ready(alu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flags(flags), .done(done), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison, half a period away from the active edge
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("dec_ready", {15'd0, dec_ready}, {15'd0, e_dr[cyc]});
            chk("rf_we",     {15'd0, rf_we},     {15'd0, e_we[cyc]});
            chk("rf_waddr",  {12'd0, rf_waddr},  {12'd0, e_addr[cyc]});
            chk("rf_wdata",  rf_wdata,           e_data[cyc]);
            chk("done",      {15'd0, done},      {15'd0, e_done[cyc]});
            chk("flags",     {12'd0, flags},     {12'd0, e_flags[cyc]});
            chk("Cflag",     {15'd0, alu_Cflag}, {15'd0, e_flags[cyc][1]});
            chk("Oflag",     {15'd0, alu_Oflag}, {15'd0, e_flags[cyc][0]});
            chk("err",       {15'd0, err},       {15'd0, e_err[cyc]});
            chk("alu_srcA",  alu_srcA,           e_a[cyc]);
            chk("alu_srcB",  alu_srcB,           e_b[cyc]);
            chk("alu_extX",  alu_extra_X,        e_x[cyc]);
            chk("alu_opsel", {11'd0, alu_opsel}, {11'd0, e_op[cyc]});
        end
    end

    task automatic model_reset(input int from);
        for (int t = from; t < MAXC; t++) begin
            e_dr[t] = 1'b1; e_we[t] = 1'b0; e_addr[t] = 4'd0; e_data[t] = 16'h0;
            e_done[t] = 1'b0; e_flags[t] = 4'd0; e_err[t] = 1'b0;
            e_a[t] = 16'h0; e_b[t] = 16'h0; e_x[t] = 16'h0; e_op[t] = 5'd0;
        end
    endtask

    task automatic next_iv();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_dec();
        dec_valid    = 1'($urandom);
        dec_srcA     = 16'($urandom);
        dec_srcB     = 16'($urandom);
        dec_extra_X  = 16'($urandom);
        dec_opsel    = 5'($urandom);
        dec_rd       = 4'($urandom);
        dec_rd_hi    = 4'($urandom);
        dec_wr_extra = 1'($urandom);
        dec_wr_flags = 1'($urandom);
    endtask

    task automatic scramble_alu();
        alu_ready     = 1'($urandom);
        alu_res       = 16'($urandom);
        alu_extra_res = 16'($urandom);
        alu_flag_next = 4'($urandom);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        dec_valid = 1'b0;
        alu_ready = 1'b0;
        err_clr   = 1'b0;
        model_reset(cyc);
        next_iv();
        next_iv();
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            dec_valid = 1'b0;
            err_clr   = 1'b0;
            scramble_alu();
            next_iv();
        end
    endtask

    task automatic clear_err();
        dec_valid = 1'b0;
        err_clr   = 1'b1;
        for (int t = cyc + 1; t < MAXC; t++) e_err[t] = 1'b0;
        next_iv();
        err_clr = 1'b0;
    endtask

    // Issue one op from an idle cycle. n = ready-low cycles before ready;
    // to = ALU never answers; rst_at = EXEC cycle index to reset in (-1: none).
    task automatic issue_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] x,
                            input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rdh,
                            input logic ext, input logic wrf, input int n, input logic to,
                            input logic clr_to, input int rst_at, input logic [15:0] res,
                            input logic [15:0] eres, input logic [3:0] fn, output int e);
        int lst;
        int nexec;
        dec_valid = 1'b1; dec_srcA = a; dec_srcB = b; dec_extra_X = x; dec_opsel = op;
        dec_rd = rd; dec_rd_hi = rdh; dec_wr_extra = ext; dec_wr_flags = wrf;
        err_clr = 1'b0;
        scramble_alu();
        e = cyc + 1;
        for (int t = e; t < MAXC; t++) begin
            e_a[t] = a; e_b[t] = b; e_x[t] = x; e_op[t] = op;
        end
        if (to) begin
            for (int t = e; t < e + MW; t++) e_dr[t] = 1'b0;
            for (int t = e + MW; t < MAXC; t++) e_err[t] = 1'b1;
        end else begin
            lst = e + n + 1 + int'(ext);
            for (int t = e; t <= lst; t++) e_dr[t] = 1'b0;
            e_we[e+n+1] = 1'b1; e_addr[e+n+1] = rd; e_data[e+n+1] = res;
            e_done[e+n+1] = !ext;
            if (ext) begin
                e_we[e+n+2] = 1'b1; e_addr[e+n+2] = rdh; e_data[e+n+2] = eres;
                e_done[e+n+2] = 1'b1;
            end
            if (wrf) for (int t = e + n + 1; t < MAXC; t++) e_flags[t] = fn;
        end
        next_iv();
        nexec = to ? MW : n + 1;
        for (int i = 0; i < nexec; i++) begin
            if (rst_at == i) begin
                do_reset();
                return;
            end
            scramble_dec();
            scramble_alu();
            err_clr = to && clr_to && (i == MW - 1);
            if (!to && i == n) begin
                alu_ready = 1'b1; alu_res = res; alu_extra_res = eres; alu_flag_next = fn;
            end else begin
                alu_ready = 1'b0;
            end
            next_iv();
        end
        err_clr = 1'b0;
        if (!to) begin
            for (int i = 0; i < 1 + int'(ext); i++) begin
                scramble_dec();
                scramble_alu();
                next_iv();
            end
        end
        dec_valid = 1'b0;
    endtask

    initial begin
        int e;
        int n, rst_at, r;
        logic to, ext, wrf;
        logic [3:0] rd, rdh;
        model_reset(0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // ADD with flag update
        issue_op(16'h7FFF, 16'h0001, 16'h0, 5'd1, 4'd3, 4'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0, -1,
                 16'h8000, 16'h0, 4'b0101, e);
        chk("pin_add_we",    {15'd0, e_we[e+1]},    16'd1);
        chk("pin_add_addr",  {12'd0, e_addr[e+1]},  16'd3);
        chk("pin_add_data",  e_data[e+1],           16'h8000);
        chk("pin_add_done",  {15'd0, e_done[e+1]},  16'd1);
        chk("pin_add_flag0", {12'd0, e_flags[e]},   16'd0);
        chk("pin_add_flag1", {12'd0, e_flags[e+1]}, 16'd5);

        // MUL with extra write
        issue_op(16'h0100, 16'h0100, 16'h0, 5'd7, 4'd2, 4'd5, 1'b1, 1'b0, 0, 1'b0, 1'b0, -1,
                 16'h0000, 16'h0001, 4'b1111, e);
        chk("pin_mul_lo",    {12'd0, e_addr[e+1]},  16'd2);
        chk("pin_mul_lodn",  {15'd0, e_done[e+1]},  16'd0);
        chk("pin_mul_hi",    {12'd0, e_addr[e+2]},  16'd5);
        chk("pin_mul_hidat", e_data[e+2],           16'h0001);
        chk("pin_mul_hidn",  {15'd0, e_done[e+2]},  16'd1);

        // slow ALU, five cycles of ready low
        issue_op(16'h1234, 16'h5678, 16'h9ABC, 5'd3, 4'd9, 4'd0, 1'b0, 1'b0, 5, 1'b0, 1'b0, -1,
                 16'hBEEF, 16'h0, 4'd0, e);
        chk("pin_slow_we5",  {15'd0, e_we[e+5]},    16'd0);
        chk("pin_slow_we6",  {15'd0, e_we[e+6]},    16'd1);
        chk("pin_slow_dr6",  {15'd0, e_dr[e+6]},    16'd0);
        chk("pin_slow_dr7",  {15'd0, e_dr[e+7]},    16'd1);

        // ready arriving in the very last allowed EXEC cycle
        issue_op(16'h0F0F, 16'hF0F0, 16'h0, 5'd2, 4'd4, 4'd0, 1'b0, 1'b0, MW - 1, 1'b0, 1'b0, -1,
                 16'h4444, 16'h0, 4'd0, e);
        chk("pin_edge_we",   {15'd0, e_we[e+MW]},   16'd1);
        chk("pin_edge_err",  {15'd0, e_err[e+MW]},  16'd0);

        // timeout, then clear
        issue_op(16'hAAAA, 16'h5555, 16'h0, 5'd4, 4'd6, 4'd0, 1'b0, 1'b1, 0, 1'b1, 1'b0, -1,
                 16'h0, 16'h0, 4'b1111, e);
        chk("pin_to_err0",   {15'd0, e_err[e+MW-1]}, 16'd0);
        chk("pin_to_err1",   {15'd0, e_err[e+MW]},   16'd1);
        chk("pin_to_dr",     {15'd0, e_dr[e+MW]},    16'd1);
        chk("pin_to_we",     {15'd0, e_we[e+MW-1]},  16'd0);
        idle(1);
        clear_err();
        chk("pin_clr_err",   {15'd0, e_err[cyc]},    16'd0);

        // timeout with err_clr on the same edge: set wins
        issue_op(16'h1111, 16'h2222, 16'h0, 5'd5, 4'd1, 4'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1, -1,
                 16'h0, 16'h0, 4'd0, e);
        chk("pin_setwins",   {15'd0, e_err[e+MW]},   16'd1);
        clear_err();

        // preload flags, then an op that must not touch them
        issue_op(16'h0, 16'h0, 16'h0, 5'd1, 4'd7, 4'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0, -1,
                 16'h0001, 16'h0, 4'b1000, e);
        issue_op(16'h3, 16'h4, 16'h0, 5'd1, 4'd8, 4'd0, 1'b0, 1'b0, 1, 1'b0, 1'b0, -1,
                 16'h0007, 16'h0, 4'b0110, e);
        chk("pin_noflag",    {12'd0, e_flags[cyc]},  16'h0008);

        // reset in the middle of an EXEC wait
        issue_op(16'hCAFE, 16'hF00D, 16'h1, 5'd9, 4'd3, 4'd4, 1'b1, 1'b1, 6, 1'b0, 1'b0, 3,
                 16'h0, 16'h0, 4'b0111, e);
        chk("pin_rst_flags", {12'd0, e_flags[cyc]},  16'd0);
        chk("pin_rst_we",    {15'd0, e_we[e+7]},     16'd0);

        // randomized traffic
        repeat (250) begin
            if (cyc > MAXC - 40) break;
            r      = $urandom_range(0, 99);
            to     = (r < 8);
            n      = $urandom_range(0, MW - 1);
            rst_at = -1;
            if (r >= 8 && r < 14) rst_at = $urandom_range(0, n);
            ext = 1'($urandom);
            wrf = 1'($urandom);
            rd  = 4'($urandom);
            rdh = ($urandom_range(0, 4) == 0) ? rd : 4'($urandom);
            issue_op(16'($urandom), 16'($urandom), 16'($urandom), 5'($urandom), rd, rdh,
                     ext, wrf, n, to, 1'($urandom), rst_at, 16'($urandom), 16'($urandom),
                     4'($urandom), e);
            if ($urandom_range(0, 9) == 0) clear_err();
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
